// File: rtl/dvp_camera_source.sv
// Purpose: DVP (OV7670-style) sensor-side pixel source producing RGB565 test patterns, high byte first.
// Latency: v_sync/h_ref/data_out are registered and only update in pclk fall slots (pclk 1->0 cycles).
// Backpressure: none; free-running source, enable and pattern_sel take effect only at frame boundaries.
// Ports: clk_25 / reset_n - sole clock and async active-low reset
//        enable, pattern_sel - run control and pattern choice (0 ramp, 1 solid, 2 checker, 3 bars)
//        pclk, v_sync, h_ref, data_out - DVP bus towards the capture path
//        frame_done, frame_count - end-of-frame pulse and completed-frame counter
module dvp_camera_source #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_TOTAL     = 784,
   parameter int unsigned V_TOTAL     = 510,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned V_START     = 17,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned BAR_W       = 80,
   parameter logic [15:0] SOLID       = 16'hF800
) (
   input  logic       clk_25,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       pclk,
   output logic       v_sync,
   output logic       h_ref,
   output logic [7:0] data_out,
   output logic       frame_done,
   output logic [7:0] frame_count
);

   // Widths sized to hold the terminal values (not just the last index)
   localparam int BW = $clog2(2 * H_TOTAL + 1);
   localparam int LW = $clog2(V_TOTAL + 1);
   localparam int PW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [BW-1:0] BYTE_LAST = BW'(2 * H_TOTAL - 1);
   localparam logic [BW-1:0] BYTE_ACT  = BW'(2 * H_ACTIVE);
   localparam logic [LW-1:0] LINE_LAST = LW'(V_TOTAL - 1);
   localparam logic [LW-1:0] VS_END    = LW'(VSYNC_LINES);
   localparam logic [LW-1:0] ACT_START = LW'(V_START);
   localparam logic [LW-1:0] ACT_END   = LW'(V_START + V_ACTIVE);
   localparam logic [PW-1:0] BAR_LAST  = PW'(BAR_W - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state, state_nx;
   logic [BW-1:0]   byte_cnt, byte_nx;
   logic [LW-1:0]   line_cnt, line_nx;
   logic [1:0]      pat_q, pat_nx;
   logic [PW-1:0]   bar_px, bar_px_nx;
   logic [2:0]      bar_idx, bar_idx_nx;
   logic            frame_end;

   logic            vs_nx;
   logic            href_nx;
   logic [7:0]      data_nx;
   logic [15:0]     pixel;
   logic [15:0]     pix_x;
   logic [15:0]     pix_y;

   // pclk is about to fall on this edge, so this is the slot that drives the bus
   logic fall_slot;
   logic last_slot;
   assign fall_slot = pclk;
   assign last_slot = (state == RUN) && (byte_cnt == BYTE_LAST) && (line_cnt == LINE_LAST);

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] c;
      c = 16'h0000;
      case (idx)
         3'd0:    c = 16'hFFFF;
         3'd1:    c = 16'hFFE0;
         3'd2:    c = 16'h07FF;
         3'd3:    c = 16'h07E0;
         3'd4:    c = 16'hF81F;
         3'd5:    c = 16'hF800;
         3'd6:    c = 16'h001F;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction

   // State and timing-counter register
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         byte_cnt <= '0;
         line_cnt <= '0;
         pat_q    <= 2'd0;
         bar_px   <= '0;
         bar_idx  <= 3'd0;
      end else begin
         state    <= state_nx;
         byte_cnt <= byte_nx;
         line_cnt <= line_nx;
         pat_q    <= pat_nx;
         bar_px   <= bar_px_nx;
         bar_idx  <= bar_idx_nx;
      end
   end

   // Next state: counters describe the byte slot currently on the bus
   always_comb begin
      state_nx   = state;
      byte_nx    = byte_cnt;
      line_nx    = line_cnt;
      pat_nx     = pat_q;
      bar_px_nx  = bar_px;
      bar_idx_nx = bar_idx;
      frame_end  = 1'b0;
      if (fall_slot) begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state_nx   = RUN;
                  byte_nx    = '0;
                  line_nx    = '0;
                  pat_nx     = pattern_sel;
                  bar_px_nx  = '0;
                  bar_idx_nx = 3'd0;
               end
            end
            RUN: begin
               if (last_slot) begin
                  frame_end  = 1'b1;
                  byte_nx    = '0;
                  line_nx    = '0;
                  bar_px_nx  = '0;
                  bar_idx_nx = 3'd0;
                  if (enable) begin
                     pat_nx = pattern_sel;
                  end else begin
                     state_nx = IDLE;
                  end
               end else if (byte_cnt == BYTE_LAST) begin
                  byte_nx    = '0;
                  line_nx    = line_cnt + LW'(1);
                  bar_px_nx  = '0;
                  bar_idx_nx = 3'd0;
               end else begin
                  byte_nx = byte_cnt + BW'(1);
                  // An odd byte ends a pixel, so the next byte starts a new one
                  if (byte_cnt[0]) begin
                     if (bar_px == BAR_LAST) begin
                        bar_px_nx = '0;
                        if (bar_idx != 3'd7) begin
                           bar_idx_nx = bar_idx + 3'd1;
                        end
                     end else begin
                        bar_px_nx = bar_px + PW'(1);
                     end
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Output decode for the slot being entered
   always_comb begin
      pix_x   = 16'(byte_nx >> 1);
      pix_y   = 16'(line_nx) - 16'(V_START);
      pixel   = 16'h0000;
      vs_nx   = 1'b0;
      href_nx = 1'b0;
      data_nx = 8'h00;
      case (pat_nx)
         2'd0:    pixel = pix_x + pix_y;
         2'd1:    pixel = SOLID;
         2'd2:    pixel = (pix_x[3] ^ pix_y[3]) ? 16'hFFFF : 16'h0000;
         default: pixel = bar_colour(bar_idx_nx);
      endcase
      if (state_nx == RUN) begin
         vs_nx   = (line_nx < VS_END);
         href_nx = (line_nx >= ACT_START) && (line_nx < ACT_END) && (byte_nx < BYTE_ACT);
         if (href_nx) begin
            data_nx = byte_nx[0] ? pixel[7:0] : pixel[15:8];
         end
      end
   end

   // Output register: bus changes only in fall slots, so it is stable at the next pclk rise
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         pclk        <= 1'b0;
         v_sync      <= 1'b0;
         h_ref       <= 1'b0;
         data_out    <= 8'h00;
         frame_done  <= 1'b0;
         frame_count <= 8'h00;
      end else begin
         pclk       <= ~pclk;
         frame_done <= frame_end;
         if (frame_end) begin
            frame_count <= frame_count + 8'd1;
         end
         if (fall_slot) begin
            v_sync   <= vs_nx;
            h_ref    <= href_nx;
            data_out <= data_nx;
         end
      end
   end

endmodule

// File: tb/tb_dvp_camera_source.sv
// Purpose: self-checking bench for dvp_camera_source with a small frame geometry.
// Latency: outputs sampled 1 time unit after each clk_25 rising edge.
// Backpressure: not applicable; the bench only drives enable, pattern_sel and reset_n.
module tb_dvp_camera_source;

   localparam int HA          = 4;
   localparam int HT          = 6;
   localparam int VT          = 6;
   localparam int VSL         = 1;
   localparam int VST         = 2;
   localparam int VACT        = 3;
   localparam int BARW        = 1;
   localparam logic [15:0] SOLID_C = 16'hF800;
   localparam int BPL         = 2 * HT;
   localparam int FRAME_SLOTS = BPL * VT;

   logic       clk_25 = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [1:0] pattern_sel;
   logic       pclk;
   logic       v_sync;
   logic       h_ref;
   logic [7:0] data_out;
   logic       frame_done;
   logic [7:0] frame_count;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: running flag, byte-slot index within the frame, latched pattern
   bit         m_run, m_fall, m_pclk, m_vs, m_href, m_done;
   int         m_k, m_count;
   logic [1:0] m_pat;
   logic [7:0] m_data;

   // Observation logs taken from the DUT outputs
   logic [7:0] cap_q[$];
   int         burst_q[$];
   int         done_q[$];
   int         vs_cnt, fall_idx, cyc, toggles;
   bit         prev_href;
   logic       prev_pclk;

   logic [7:0] exp_ramp_l2 [8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
   logic [7:0] exp_ramp_l4 [8] = '{8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05};
   logic [7:0] exp_bars_l2 [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0};

   dvp_camera_source #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .V_TOTAL(VT), .VSYNC_LINES(VSL),
      .V_START(VST), .V_ACTIVE(VACT), .BAR_W(BARW), .SOLID(SOLID_C)
   ) dut (
      .clk_25(clk_25),
      .reset_n(reset_n),
      .enable(enable),
      .pattern_sel(pattern_sel),
      .pclk(pclk),
      .v_sync(v_sync),
      .h_ref(h_ref),
      .data_out(data_out),
      .frame_done(frame_done),
      .frame_count(frame_count)
   );

   always #5 clk_25 = ~clk_25;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] bar_colour(input int idx);
      case (idx)
         0:       return 16'hFFFF;
         1:       return 16'hFFE0;
         2:       return 16'h07FF;
         3:       return 16'h07E0;
         4:       return 16'hF81F;
         5:       return 16'hF800;
         6:       return 16'h001F;
         default: return 16'h0000;
      endcase
   endfunction

   // Expected {v_sync, h_ref, data} for byte slot k of a frame, straight from line/column arithmetic
   function automatic logic [9:0] exp_slot(input logic [1:0] pat, input int k);
      int line, b, x, y, bar;
      logic [15:0] pixel;
      bit vs, hr;
      logic [7:0] d;
      line = k / BPL;
      b    = k % BPL;
      vs   = (line < VSL);
      hr   = (line >= VST) && (line < VST + VACT) && (b < 2 * HA);
      x    = b / 2;
      y    = line - VST;
      bar  = x / BARW;
      if (bar > 7) bar = 7;
      case (pat)
         2'd0:    pixel = 16'(x + y);
         2'd1:    pixel = SOLID_C;
         2'd2:    pixel = (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
         default: pixel = bar_colour(bar);
      endcase
      if (!hr)            d = 8'h00;
      else if (b % 2 == 0) d = pixel[15:8];
      else                d = pixel[7:0];
      return {vs, hr, d};
   endfunction

   task automatic model_reset();
      m_run = 0; m_fall = 0; m_pclk = 0; m_vs = 0; m_href = 0; m_done = 0;
      m_k = 0; m_count = 0; m_data = 8'h00;
   endtask

   task automatic clear_logs();
      cap_q.delete();
      burst_q.delete();
      done_q.delete();
      vs_cnt = 0; fall_idx = 0; toggles = 0; prev_href = 0;
   endtask

   // One clk_25 cycle: advance the model, compare every output, log DUT behaviour
   task automatic tick();
      logic [9:0] e;
      @(posedge clk_25);
      #1;
      cyc++;
      m_fall = 0;
      m_done = 0;
      if (!reset_n) begin
         model_reset();
      end else begin
         if (m_pclk) begin
            m_fall = 1;
            if (!m_run) begin
               if (enable) begin
                  m_run = 1; m_k = 0; m_pat = pattern_sel;
               end
            end else if (m_k == FRAME_SLOTS - 1) begin
               m_done  = 1;
               m_count = (m_count + 1) % 256;
               if (enable) begin
                  m_k = 0; m_pat = pattern_sel;
               end else begin
                  m_run = 0;
               end
            end else begin
               m_k++;
            end
            e = m_run ? exp_slot(m_pat, m_k) : 10'd0;
            {m_vs, m_href, m_data} = e;
         end
         m_pclk = !m_pclk;
      end
      check("pclk", pclk, m_pclk);
      check("v_sync", v_sync, m_vs);
      check("h_ref", h_ref, m_href);
      check("data_out", data_out, m_data);
      check("frame_done", frame_done, m_done);
      check("frame_count", frame_count, m_count[7:0]);
      if (pclk !== prev_pclk) toggles++;
      prev_pclk = pclk;
      if (frame_done) done_q.push_back(cyc);
      if (reset_n && !pclk) begin
         if (v_sync) vs_cnt++;
         if (h_ref) cap_q.push_back(data_out);
         if (h_ref && !prev_href) burst_q.push_back(fall_idx);
         prev_href = h_ref;
         fall_idx++;
      end
   endtask

   // Run until the model drives slot k in a fall slot, bounded by budget cycles
   task automatic seek(input int k, input int budget, input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(m_fall && m_run && m_k == k) && n < budget);
      check({"seek_", tag}, {31'd0, (m_fall && m_run && m_k == k)}, 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      reset_n = 0; enable = 0; pattern_sel = 2'd0;
      m_pat = 2'd0; cyc = 0; prev_pclk = 1'b0;
      model_reset();
      clear_logs();

      // Reset state
      repeat (3) tick();
      check("rst_pclk", pclk, 0);
      check("rst_vsync", v_sync, 0);
      check("rst_href", h_ref, 0);
      check("rst_data", data_out, 0);
      check("rst_fcount", frame_count, 0);

      // Frame 1, ramp pattern: timing and byte content
      reset_n = 1; enable = 1; pattern_sel = 2'd0;
      clear_logs();
      repeat (145) tick();
      check("vsync_slots", vs_cnt, 12);
      check("href_bytes", cap_q.size(), 24);
      check("burst_count", burst_q.size(), 3);
      if (burst_q.size() == 3) begin
         check("burst_gap1", burst_q[1] - burst_q[0], 12);
         check("burst_gap2", burst_q[2] - burst_q[1], 12);
      end
      if (cap_q.size() == 24) begin
         for (int i = 0; i < 8; i++) begin
            check("ramp_line2", cap_q[i], exp_ramp_l2[i]);
            check("ramp_line4", cap_q[16 + i], exp_ramp_l4[i]);
         end
      end
      check("no_done_yet", done_q.size(), 0);

      // Frame 2 solid; switching to checkerboard mid-frame must not affect it
      pattern_sel = 2'd1;
      clear_logs();
      repeat (60) tick();
      pattern_sel = 2'd2;
      repeat (84) tick();
      check("solid_bytes", cap_q.size(), 24);
      bad = 0;
      foreach (cap_q[i]) if (cap_q[i] !== ((i % 2 == 0) ? 8'hF8 : 8'h00)) bad++;
      check("solid_pairs_bad", bad, 0);
      check("done_count_f1", done_q.size(), 1);
      check("fcount_1", frame_count, 1);

      // Frame 3 checkerboard, frame period
      repeat (144) tick();
      check("done_count_f2", done_q.size(), 2);
      if (done_q.size() == 2) check("frame_period", done_q[1] - done_q[0], 144);
      check("fcount_2", frame_count, 2);

      // Drop enable during line 3: frame completes, then bus stays quiet
      seek(3 * BPL + 1, 200, "line3");
      enable = 0;
      clear_logs();
      repeat (100) tick();
      check("drop_done_once", done_q.size(), 1);
      clear_logs();
      repeat (500) tick();
      check("idle_done", done_q.size(), 0);
      check("idle_vsync", vs_cnt, 0);
      check("idle_href", cap_q.size(), 0);
      check("idle_pclk_toggles", toggles, 500);

      // Colour bars
      pattern_sel = 2'd3; enable = 1;
      clear_logs();
      seek(2 * BPL + 7, 300, "bars_line2");
      check("bars_bytes", cap_q.size(), 8);
      if (cap_q.size() >= 8) begin
         for (int i = 0; i < 8; i++) check("bars_line2", cap_q[i], exp_bars_l2[i]);
      end

      // Async reset during active line 3
      seek(3 * BPL + 2, 200, "line3_active");
      tick();
      #2;
      reset_n = 0;
      #1;
      check("arst_pclk", pclk, 0);
      check("arst_vsync", v_sync, 0);
      check("arst_href", h_ref, 0);
      check("arst_data", data_out, 0);
      check("arst_done", frame_done, 0);
      check("arst_fcount", frame_count, 0);
      model_reset();
      repeat (3) tick();
      reset_n = 1;
      tick();
      tick();
      check("restart_vsync", v_sync, 1);
      check("restart_fcount", frame_count, 0);

      // Randomised run: pattern changes and enable toggles at arbitrary points
      for (int i = 0; i < 4000; i++) begin
         tick();
         if ($urandom_range(0, 39) == 0) pattern_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 249) == 0) enable = !enable;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dvp_camera_source.md
Name: dvp_camera_source

Overview:
- Synthesizable DVP (OV7670-style) pixel source. It drives the sensor end of the parallel camera interface: pclk, v_sync, h_ref and an 8-bit data bus.
- Feeds the camera capture path in simulation and in hardware bring-up when no sensor is fitted.
- Generates RGB565 test patterns, high byte first, with programmable frame timing.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 784, total pixel periods per line (active + blank); must be > H_ACTIVE
- V_TOTAL, 510, lines per frame
- VSYNC_LINES, 3, lines with v_sync high, starting at line 0
- V_START, 17, first active line; V_START >= VSYNC_LINES
- V_ACTIVE, 480, active lines; V_START + V_ACTIVE <= V_TOTAL
- BAR_W, 80, pixels per colour bar
- SOLID, 16'hF800, RGB565 value for the solid pattern

Ports:
- clk_25  in  1  system clock; the only clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run frames; sampled at frame boundaries only
- pattern_sel  in  2  0 = x+y ramp, 1 = solid, 2 = checkerboard, 3 = colour bars
- pclk  out  1  pixel byte clock, clk_25/2, registered
- v_sync  out  1  frame sync, active high
- h_ref  out  1  byte valid, active high
- data_out  out  8  pixel byte
- frame_done  out  1  one clk_25 pulse at end of each frame
- frame_count  out  8  completed frames, wraps 255 -> 0

Behaviour:
- Reset (async, reset_n low): all outputs 0; counters 0; state IDLE.
- pclk: toggles every clk_25 cycle from the first edge after reset release. It free-runs in every state.
- Fall slot: the cycle in which pclk goes 1 -> 0.
  - v_sync, h_ref and data_out change only in fall slots.
  - They are stable across the following pclk rise, so the receiver samples on the pclk rising edge.
- Byte slot: one per fall slot.
  - byte_cnt runs 0 .. 2*H_TOTAL-1.
  - line_cnt runs 0 .. V_TOTAL-1 and increments when byte_cnt wraps.
- States:
  - IDLE: outputs low, counters held at 0.
  - RUN: timing counters advance.
  - IDLE -> RUN at a fall slot with enable=1. That slot drives line 0, byte 0 (v_sync=1).
- v_sync = (line_cnt < VSYNC_LINES).
- h_ref = (V_START <= line_cnt < V_START+V_ACTIVE) and (byte_cnt < 2*H_ACTIVE).
- Pixel coordinates:
  - x = byte_cnt>>1; y = line_cnt - V_START.
  - Even byte carries pixel[15:8]; odd byte carries pixel[7:0].
  - data_out = 0 whenever h_ref = 0.
- Patterns (16-bit arithmetic, truncated):
  - 0: pixel = x + y.
  - 1: pixel = SOLID.
  - 2: pixel = (x[3]^y[3]) ? 16'hFFFF : 16'h0000.
  - 3: bar index increments every BAR_W pixels, resets at line start, saturates at 7. Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- pattern_sel is latched on entry to line 0 of each frame. Changes mid-frame take effect next frame.
- End of frame: the fall slot after line V_TOTAL-1, byte 2*H_TOTAL-1.
  - frame_done pulses high for exactly that one clk_25 cycle.
  - frame_count increments (255 wraps to 0).
  - If enable=1, this slot drives line 0 of the next frame with no gap; otherwise go to IDLE with outputs low.
- enable deasserted mid-frame: the current frame completes fully.
- reset_n asserted mid-frame: immediate return to reset values. After release, a new frame starts from line 0 only once enable is seen.

Test Plan:
All cases use H_ACTIVE=4, H_TOTAL=6, V_TOTAL=6, VSYNC_LINES=1, V_START=2, V_ACTIVE=3, BAR_W=1.
- Reset, then enable=1, pattern 0:
  - v_sync high for exactly 12 pclk periods.
  - h_ref high in 3 bursts of 8 bytes, bursts 12 pclk apart.
  - Line 2 bytes: 00,00,00,01,00,02,00,03.
  - Line 4 bytes: 00,02,00,03,00,04,00,05.
- Frame length: frame_done pulses every 144 clk_25 cycles; single-cycle pulse; frame_count 0 -> 1 -> 2.
- pattern_sel=1 with SOLID=F800 → every active byte pair is F8,00. Switching to 2 mid-frame has no effect until the next v_sync rise.
- enable dropped at line 3 → the frame completes, frame_done pulses once, then v_sync, h_ref and data stay 0 for 500 cycles while pclk keeps toggling.
- pattern_sel=3 → line 2 bytes: FF,FF,FF,E0,07,FF,07,E0.
- reset_n pulsed low during the active line at line_cnt=3 → all outputs 0 asynchronously. After release with enable=1, v_sync rises on the first fall slot. frame_count is 0.
